// File: rtl/trap_ctrl_pkg.sv
// Shared trap sequencer definitions: address width, FSM encoding,
// cause codes and the event bundle handed from arbitration to the latches.
package trap_ctrl_pkg;

    localparam int BUS_ADDR_MEM = 32;

    localparam logic [2:0] TRAP_ST_IDLE  = 3'd0;
    localparam logic [2:0] TRAP_ST_DRAIN = 3'd1;
    localparam logic [2:0] TRAP_ST_TRAP  = 3'd2;
    localparam logic [2:0] TRAP_ST_JUMP  = 3'd3;
    localparam logic [2:0] TRAP_ST_HOLD  = 3'd4;

    localparam logic [3:0] TRAP_CAUSE_MISALIGN = 4'd0;
    localparam logic [3:0] TRAP_CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] TRAP_CAUSE_EBREAK   = 4'd3;
    localparam logic [3:0] TRAP_CAUSE_ECALL    = 4'd11;
    localparam logic [3:0] TRAP_CAUSE_EXT      = 4'd11;
    localparam logic [3:0] TRAP_CAUSE_SFT      = 4'd3;
    localparam logic [3:0] TRAP_CAUSE_TMR      = 4'd7;
    localparam logic [3:0] TRAP_CAUSE_MRET     = 4'd0;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_EXP,
        KIND_IRQ,
        KIND_MRET
    } trap_kind_t;

    typedef struct packed {
        trap_kind_t kind;
        logic [4:0] cause;
    } trap_evt_t;

    // req = {misalign, ebreak, ecall, illegal}
    function automatic logic [3:0] exp_code(input logic [3:0] req);
        if (req[3])      return TRAP_CAUSE_MISALIGN;
        else if (req[0]) return TRAP_CAUSE_ILLEGAL;
        else if (req[2]) return TRAP_CAUSE_EBREAK;
        else if (req[1]) return TRAP_CAUSE_ECALL;
        else             return TRAP_CAUSE_MISALIGN;
    endfunction

endpackage

// File: rtl/trap_ctrl_sync.sv
// Flop-chain synchronizer for the asynchronous external interrupt line.
// All stages clear to 0 on reset.
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= (chain << 1) | STAGES'(d);
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer ahead of ex_csr: arbitrates exceptions, mret and
// interrupts, drains memory, strobes ex_csr, then redirects and flushes.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_irq_i,
    input  logic                    sft_irq_i,
    input  logic                    tmr_irq_i,
    input  logic                    meie_i,
    input  logic                    msie_i,
    input  logic                    mtie_i,
    input  logic                    glb_irq_i,
    input  logic                    ex_vld_i,
    input  logic [BUS_ADDR_MEM-1:0] ex_pc_i,
    input  logic [3:0]              exp_req_i,
    input  logic                    mret_i,
    input  logic                    mem_busy_i,
    input  logic [BUS_ADDR_MEM-1:0] irq_pc_i,
    input  logic [BUS_ADDR_MEM-1:0] mepc_i,
    output logic                    irq_src_o,
    output logic                    exp_src_o,
    output logic                    mret_ena_o,
    output logic [BUS_ADDR_MEM-1:0] trap_pc_o,
    output logic [4:0]              trap_cause_o,
    output logic                    stall_o,
    output logic                    flush_o,
    output logic                    jump_o,
    output logic [BUS_ADDR_MEM-1:0] jump_addr_o
);

    logic       ext_s;
    logic       ext_en;
    logic       sft_en;
    logic       tmr_en;
    logic       take;
    logic [2:0] state;
    logic [2:0] state_d;
    trap_kind_t kind_q;
    trap_evt_t  evt;

    irq_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ext_irq_i),
        .q    (ext_s)
    );

    assign ext_en = ext_s & meie_i & glb_irq_i;
    assign sft_en = sft_irq_i & msie_i & glb_irq_i;
    assign tmr_en = tmr_irq_i & mtie_i & glb_irq_i;

    always_comb begin
        evt = '{kind: KIND_NONE, cause: 5'd0};
        if (|exp_req_i) begin
            evt = '{kind: KIND_EXP, cause: {1'b0, exp_code(exp_req_i)}};
        end else if (mret_i) begin
            evt = '{kind: KIND_MRET, cause: {1'b0, TRAP_CAUSE_MRET}};
        end else if (ext_en) begin
            evt = '{kind: KIND_IRQ, cause: {1'b1, TRAP_CAUSE_EXT}};
        end else if (sft_en) begin
            evt = '{kind: KIND_IRQ, cause: {1'b1, TRAP_CAUSE_SFT}};
        end else if (tmr_en) begin
            evt = '{kind: KIND_IRQ, cause: {1'b1, TRAP_CAUSE_TMR}};
        end
    end

    // Sampling only in IDLE keeps events masked through DRAIN..HOLD.
    assign take = (state == TRAP_ST_IDLE) && ex_vld_i
                  && (evt.kind != KIND_NONE);

    always_comb begin
        state_d = state;
        unique case (state)
            TRAP_ST_IDLE: begin
                if (take) begin
                    state_d = mem_busy_i ? TRAP_ST_DRAIN : TRAP_ST_TRAP;
                end
            end
            TRAP_ST_DRAIN: begin
                if (!mem_busy_i) begin
                    state_d = TRAP_ST_TRAP;
                end
            end
            TRAP_ST_TRAP: state_d = TRAP_ST_JUMP;
            TRAP_ST_JUMP: state_d = TRAP_ST_HOLD;
            TRAP_ST_HOLD: state_d = TRAP_ST_IDLE;
            default:      state_d = TRAP_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= TRAP_ST_IDLE;
            kind_q       <= KIND_NONE;
            trap_cause_o <= '0;
            trap_pc_o    <= '0;
        end else begin
            state <= state_d;
            if (take) begin
                kind_q       <= evt.kind;
                trap_cause_o <= evt.cause;
                trap_pc_o    <= ex_pc_i;
            end
        end
    end

    assign stall_o = (state == TRAP_ST_DRAIN) || (state == TRAP_ST_TRAP)
                     || (state == TRAP_ST_JUMP);

    assign exp_src_o  = (state == TRAP_ST_TRAP) && (kind_q == KIND_EXP);
    assign irq_src_o  = (state == TRAP_ST_TRAP) && (kind_q == KIND_IRQ);
    assign mret_ena_o = (state == TRAP_ST_TRAP) && (kind_q == KIND_MRET);

    assign flush_o = (state == TRAP_ST_JUMP);
    assign jump_o  = (state == TRAP_ST_JUMP);

    // ex_csr has already taken the TRAP-edge update, so these are final.
    always_comb begin
        jump_addr_o = '0;
        if (state == TRAP_ST_JUMP) begin
            jump_addr_o = (kind_q == KIND_MRET) ? mepc_i : irq_pc_i;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic, checked
// every cycle against a timeline model of the trap sequence.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_irq_i = 0, sft_irq_i = 0, tmr_irq_i = 0;
    logic        meie_i = 0, msie_i = 0, mtie_i = 0, glb_irq_i = 0;
    logic        ex_vld_i = 0, mret_i = 0, mem_busy_i = 0;
    logic [3:0]  exp_req_i = 0;
    logic [31:0] ex_pc_i = 0, irq_pc_i = 0, mepc_i = 0;
    logic        irq_src_o, exp_src_o, mret_ena_o;
    logic        stall_o, flush_o, jump_o;
    logic [31:0] trap_pc_o, jump_addr_o;
    logic [4:0]  trap_cause_o;

    int tests = 0;
    int fails = 0;
    int n_strb = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n),
        .ext_irq_i(ext_irq_i), .sft_irq_i(sft_irq_i), .tmr_irq_i(tmr_irq_i),
        .meie_i(meie_i), .msie_i(msie_i), .mtie_i(mtie_i),
        .glb_irq_i(glb_irq_i), .ex_vld_i(ex_vld_i), .ex_pc_i(ex_pc_i),
        .exp_req_i(exp_req_i), .mret_i(mret_i), .mem_busy_i(mem_busy_i),
        .irq_pc_i(irq_pc_i), .mepc_i(mepc_i),
        .irq_src_o(irq_src_o), .exp_src_o(exp_src_o),
        .mret_ena_o(mret_ena_o), .trap_pc_o(trap_pc_o),
        .trap_cause_o(trap_cause_o), .stall_o(stall_o),
        .flush_o(flush_o), .jump_o(jump_o), .jump_addr_o(jump_addr_o)
    );

    // Timeline model: a committed trap occupies edges trap_e..trap_e+3.
    int          e = 0;
    bit          m_act = 0, m_drain = 0, m_mret = 0;
    int          m_trap_e = 0;
    logic [4:0]  m_cause = 0;
    logic [31:0] m_pc = 0;
    logic        m_q[$];

    task automatic model_reset();
        m_act = 0; m_drain = 0; m_mret = 0;
        m_cause = 0; m_pc = 0;
        m_q.delete();
        for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
    endtask

    function automatic bit pick(input logic vis, output logic [4:0] c,
                                output bit is_mret);
        bit         req[8];
        logic [4:0] code[8];
        req  = '{exp_req_i[3], exp_req_i[0], exp_req_i[2], exp_req_i[1],
                 mret_i, vis & meie_i & glb_irq_i,
                 sft_irq_i & msie_i & glb_irq_i,
                 tmr_irq_i & mtie_i & glb_irq_i};
        code = '{5'h00, 5'h02, 5'h03, 5'h0B, 5'h00, 5'h1B, 5'h13, 5'h17};
        c = 5'h00;
        is_mret = 0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                c = code[i];
                is_mret = (i == 4);
                return 1;
            end
        end
        return 0;
    endfunction

    task automatic model_step();
        logic       vis;
        logic [4:0] c;
        bit         mr;
        vis = m_q[SYNC-1];
        m_q.push_front(ext_irq_i);
        void'(m_q.pop_back());
        e++;
        if (!m_act) begin
            if (ex_vld_i && pick(vis, c, mr)) begin
                m_act = 1; m_mret = mr; m_cause = c; m_pc = ex_pc_i;
                if (mem_busy_i) m_drain = 1;
                else m_trap_e = e;
            end
        end else if (m_drain) begin
            if (!mem_busy_i) begin
                m_drain = 0;
                m_trap_e = e;
            end
        end else if (e == m_trap_e + 3) begin
            m_act = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        int          ph;
        bit          stb;
        logic [31:0] ja;
        ph  = (m_act && !m_drain) ? (e - m_trap_e) : -1;
        stb = (ph == 0);
        ja  = (ph == 1) ? (m_mret ? mepc_i : irq_pc_i) : 32'h0;
        chk("stall", stall_o, m_act && (m_drain || ph == 0 || ph == 1));
        chk("exp_src", exp_src_o, stb && !m_mret && !m_cause[4]);
        chk("irq_src", irq_src_o, stb && m_cause[4]);
        chk("mret_ena", mret_ena_o, stb && m_mret);
        chk("jump", jump_o, ph == 1);
        chk("flush", flush_o, ph == 1);
        chk("jump_addr", jump_addr_o, ja);
        chk("trap_pc", trap_pc_o, m_pc);
        chk("trap_cause", {27'd0, trap_cause_o}, {27'd0, m_cause});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk_all();
        if (irq_src_o || exp_src_o || mret_ena_o) n_strb++;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_out"}, {stall_o, flush_o, jump_o, irq_src_o,
                            exp_src_o, mret_ena_o}, 0);
        chk({tag, "_ja"}, jump_addr_o, 0);
        chk({tag, "_pc"}, trap_pc_o, 0);
        chk({tag, "_cause"}, {27'd0, trap_cause_o}, 0);
    endtask

    initial begin : main
        bit got;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1;

        // Illegal exception, no drain
        ex_vld_i = 1; exp_req_i = 4'b0001;
        ex_pc_i = 32'h8000_0010; irq_pc_i = 32'h8000_0100;
        cycle();
        chk("t1_exp_src", exp_src_o, 1);
        chk("t1_pc", trap_pc_o, 32'h8000_0010);
        chk("t1_cause", {27'd0, trap_cause_o}, 32'h02);
        exp_req_i = 0;
        cycle();
        chk("t1_jump", {jump_o, flush_o}, 2'b11);
        chk("t1_jaddr", jump_addr_o, 32'h8000_0100);
        repeat (3) cycle();

        // Timer interrupt behind three busy cycles
        tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; mem_busy_i = 1;
        repeat (3) begin
            cycle();
            chk("t2_stall", stall_o, 1);
        end
        mem_busy_i = 0;
        cycle();
        chk("t2_irq_src", irq_src_o, 1);
        chk("t2_cause", {27'd0, trap_cause_o}, 32'h17);
        tmr_irq_i = 0;
        repeat (4) cycle();

        // mret with a software interrupt pending
        mret_i = 1; mepc_i = 32'h8000_0024; sft_irq_i = 1; msie_i = 1;
        cycle();
        chk("t3_mret", mret_ena_o, 1);
        mret_i = 0;
        cycle();
        chk("t3_jaddr", jump_addr_o, 32'h8000_0024);
        cycle();
        chk("t3_hold_noirq", irq_src_o, 0);
        cycle();
        chk("t3_idle_noirq", irq_src_o, 0);
        cycle();
        chk("t3_sft_taken", irq_src_o, 1);
        sft_irq_i = 0;
        repeat (4) cycle();

        // ecall together with an external interrupt
        exp_req_i = 4'b0010; ext_irq_i = 1; meie_i = 1;
        cycle();
        chk("t4_ecall", exp_src_o, 1);
        chk("t4_ecall_cause", {27'd0, trap_cause_o}, 32'h0B);
        exp_req_i = 0;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            cycle();
            got = irq_src_o;
        end
        chk("t4_ext_seen", got, 1);
        chk("t4_ext_cause", {27'd0, trap_cause_o}, 32'h1B);
        ext_irq_i = 0;
        repeat (5) cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ex_vld_i   = ($urandom % 4) != 0;
            exp_req_i  = ($urandom % 8 == 0) ? 4'($urandom) : 4'd0;
            mret_i     = ($urandom % 10) == 0;
            mem_busy_i = ($urandom % 3) == 0;
            if ($urandom % 6 == 0) ext_irq_i = ~ext_irq_i;
            if ($urandom % 6 == 0) sft_irq_i = ~sft_irq_i;
            if ($urandom % 6 == 0) tmr_irq_i = ~tmr_irq_i;
            {meie_i, msie_i, mtie_i} = 3'($urandom);
            glb_irq_i  = ($urandom % 4) != 0;
            ex_pc_i    = $urandom & 32'hFFFF_FFFC;
            irq_pc_i   = $urandom & 32'hFFFF_FFFC;
            mepc_i     = $urandom & 32'hFFFF_FFFC;
            cycle();
        end
        exp_req_i = 0; mret_i = 0; mem_busy_i = 0; ex_vld_i = 0;
        repeat (6) cycle();

        // Global enable off
        glb_irq_i = 0; ex_vld_i = 1;
        {ext_irq_i, sft_irq_i, tmr_irq_i} = 3'b111;
        {meie_i, msie_i, mtie_i} = 3'b111;
        n_strb = 0;
        repeat (20) cycle();
        chk("glb_off_strobes", n_strb, 0);

        // Reset pulse while draining
        exp_req_i = 4'b0001; mem_busy_i = 1; ex_pc_i = 32'h8000_0040;
        cycle();
        cycle();
        chk("t5_drain_stall", stall_o, 1);
        rst_n = 0;
        #1;
        chk_zero("t5_rst");
        model_reset();
        exp_req_i = 0; mem_busy_i = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        n_strb = 0;
        repeat (8) cycle();
        chk("t5_no_strobe", n_strb, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
